beta_regfile_mp: RTL and testbench

//  Parametrised multi-read-port register file for the Beta datapath; successor to the fixed 32x32 2R1W file.

---
 rtl/beta_regfile_mp.sv | 108 ++++++++++
 tb/tb_beta_regfile_mp.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/beta_regfile_mp.sv
// Parametrised multi-read-port register file: hardwired zero register, self-clearing reset sweep with busy flag.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module beta_regfile_mp #(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 32,
  parameter  int NUM_RD   = 2,
  parameter  int ZERO_REG = DEPTH - 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_RD*AW-1:0]    ra,
  output logic [NUM_RD*WIDTH-1:0] rd,
  input  logic                    we,
  input  logic [AW-1:0]           wa,
  input  logic [WIDTH-1:0]        wd,
  output logic                    busy
);

  typedef enum logic {CLEAR, RUN} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             mem_we;
  logic [AW-1:0]    mem_wa;
  logic [WIDTH-1:0] mem_wd;
  logic             wr_ok;

  // A legal architectural write: not the zero register and inside the populated range.
  assign wr_ok = we && (wa != AW'(ZERO_REG)) && (int'(wa) < DEPTH);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    mem_we  = 1'b0;
    mem_wa  = wa;
    mem_wd  = wd;
    case (state_q)
      CLEAR: begin
        mem_we = 1'b1;
        mem_wa = idx_q;
        mem_wd = '0;
        idx_d  = idx_q + 1'b1;
        busy_d = 1'b1;
        if (idx_q == AW'(DEPTH - 1)) begin
          state_d = RUN;
          idx_d   = '0;
          busy_d  = 1'b0;
        end
      end
      RUN: begin
        mem_we = wr_ok;
        busy_d = 1'b0;
      end
      default: begin
        state_d = CLEAR;
        idx_d   = '0;
        busy_d  = 1'b1;
      end
    endcase
    // Reset wins over both a sweep step and an in-flight write.
    if (rst) mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      idx_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] rd_i;

    assign a = ra[i*AW +: AW];

    always_comb begin
      rd_i = '0;
      if (!busy_q && (a != AW'(ZERO_REG)) && (int'(a) < DEPTH)) begin
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (wa == a)) rd_i = wd;
        else                    rd_i = mem_q[a];
`else
        rd_i = mem_q[a];
`endif
      end
    end

    assign rd[i*WIDTH +: WIDTH] = rd_i;
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_beta_regfile_mp.sv
// Self-checking bench: a 32x32 2-port file and a 24-entry 3-port file against a behavioural model.
module tb_beta_regfile_mp;
  localparam int W  = 32;
  localparam int D0 = 32, N0 = 2, A0 = 5;
  localparam int D1 = 24, N1 = 3, A1 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst0, we0, busy0;
  logic [A0-1:0]     wa0;
  logic [W-1:0]      wd0;
  logic [N0*A0-1:0]  ra0;
  logic [N0*W-1:0]   rd0;

  logic              rst1, we1, busy1;
  logic [A1-1:0]     wa1;
  logic [W-1:0]      wd1;
  logic [N1*A1-1:0]  ra1;
  logic [N1*W-1:0]   rd1;

  beta_regfile_mp #(.WIDTH(W), .DEPTH(D0), .NUM_RD(N0)) dut0 (
    .clk(clk), .rst(rst0), .ra(ra0), .rd(rd0), .we(we0), .wa(wa0), .wd(wd0), .busy(busy0));
  beta_regfile_mp #(.WIDTH(W), .DEPTH(D1), .NUM_RD(N1)) dut1 (
    .clk(clk), .rst(rst1), .ra(ra1), .rd(rd1), .we(we1), .wa(wa1), .wd(wd1), .busy(busy1));

  // Reference state: register contents, busy flag, entries cleared so far in the sweep
  logic [W-1:0] m0 [D0];
  logic [W-1:0] m1 [D1];
  bit           bz0, bz1;
  int           c0, c1;
  int           checks = 0, errors = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] e0(input int p);
    int a;
    a = int'(ra0[p*A0 +: A0]);
    if (bz0 || a == D0 - 1 || a >= D0) return '0;
    if (BYP && we0 && int'(wa0) == a) return wd0;
    return m0[a];
  endfunction

  function automatic logic [W-1:0] e1(input int p);
    int a;
    a = int'(ra1[p*A1 +: A1]);
    if (bz1 || a == D1 - 1 || a >= D1) return '0;
    if (BYP && we1 && int'(wa1) == a) return wd1;
    return m1[a];
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".busy0"}, W'(busy0), W'(bz0));
    chk({tag, ".busy1"}, W'(busy1), W'(bz1));
    for (int p = 0; p < N0; p++) chk($sformatf("%s.d0rd%0d", tag, p), rd0[p*W +: W], e0(p));
    for (int p = 0; p < N1; p++) chk($sformatf("%s.d1rd%0d", tag, p), rd1[p*W +: W], e1(p));
  endtask

  // Apply one rising edge to the model using the inputs currently driven, then to the DUTs.
  task automatic tick();
    if (rst0) begin bz0 = 1'b1; c0 = 0; end
    else if (bz0) begin m0[c0] = '0; c0++; if (c0 == D0) bz0 = 1'b0; end
    else if (we0 && int'(wa0) != D0 - 1 && int'(wa0) < D0) m0[int'(wa0)] = wd0;
    if (rst1) begin bz1 = 1'b1; c1 = 0; end
    else if (bz1) begin m1[c1] = '0; c1++; if (c1 == D1) bz1 = 1'b0; end
    else if (we1 && int'(wa1) != D1 - 1 && int'(wa1) < D1) m1[int'(wa1)] = wd1;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_in();
    we0 = 1'($urandom); wa0 = A0'($urandom); wd0 = $urandom; ra0 = (N0*A0)'($urandom);
    we1 = 1'($urandom); wa1 = A1'($urandom); wd1 = $urandom; ra1 = (N1*A1)'($urandom);
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; rst0 = 1'b0; rst1 = 1'b0;
  endtask

  initial begin
    int n;
    rst0 = 1'b1; rst1 = 1'b1; idle(); rst0 = 1'b1; rst1 = 1'b1;
    wa0 = '0; wd0 = '0; ra0 = '0; wa1 = '0; wd1 = '0; ra1 = '0;
    bz0 = 1'b1; bz1 = 1'b1; c0 = 0; c1 = 0;
    @(negedge clk);
    tick();
    chk("rst.busy0", W'(busy0), W'(1));
    chk("rst.busy1", W'(busy1), W'(1));
    rst0 = 1'b0; rst1 = 1'b0;

    // Sweep with write noise on the inputs; busy0 must hold for exactly 32 edges.
    n = 0;
    while (busy0 && n < 40) begin
      rand_in(); #1; check_all("sweep"); tick(); n++;
    end
    chk("sweep_len", W'(n), W'(32));
    check_all("post_sweep");

    idle();
    for (int a = 0; a < 32; a++) begin
      ra0 = {A0'((a + 1) % 32), A0'(a)};
      ra1 = {A1'((a + 2) % 32), A1'((a + 1) % 32), A1'(a)};
      #1; check_all("clean");
      chk($sformatf("clean.zero%0d", a), rd0[0 +: W], '0);
    end

    // Write r5, neighbour stays 0.
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; ra0 = {5'd4, 5'd5};
    tick(); we0 = 1'b0; #1;
    check_all("t2");
    chk("t2.r5", rd0[0 +: W], 32'hDEADBEEF);
    chk("t2.r4", rd0[W +: W], '0);

    // Writes to the zero register are discarded.
    we0 = 1'b1; wa0 = 5'd31; wd0 = 32'hFFFFFFFF; ra0 = {5'd31, 5'd31};
    tick(); we0 = 1'b0;
    tick(); tick();
    chk("t3.r31", rd0[0 +: W], '0);
    check_all("t3");

    // Same-cycle read of the register being written.
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h12345678; ra0 = {5'd6, 5'd7}; #1;
    chk("t4.same", rd0[0 +: W], BYP ? 32'h12345678 : 32'h0);
    check_all("t4.same");
    tick(); we0 = 1'b0; #1;
    chk("t4.next", rd0[0 +: W], 32'h12345678);

    // Smaller file: r20 readable on two ports, r27 is past the end.
    we1 = 1'b1; wa1 = 5'd20; wd1 = 32'h0F0F0F0F; ra1 = {5'd27, 5'd20, 5'd20};
    tick(); we1 = 1'b0; #1;
    chk("t6.p0", rd1[0 +: W], 32'h0F0F0F0F);
    chk("t6.p1", rd1[W +: W], 32'h0F0F0F0F);
    chk("t6.p2", rd1[2*W +: W], '0);
    we1 = 1'b1; wa1 = 5'd27; wd1 = 32'hCAFEF00D; #1;
    chk("t6.oor_same", rd1[2*W +: W], '0);
    tick(); we1 = 1'b0; #1;
    chk("t6.oor", rd1[2*W +: W], '0);
    check_all("t6");

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      rand_in();
      rst0 = ($urandom_range(0, 79) == 0);
      rst1 = ($urandom_range(0, 79) == 0);
      #1; check_all("rand"); tick();
    end
    idle();
    n = 0;
    while ((busy0 || busy1) && n < 40) begin tick(); n++; end
    check_all("rand_settle");

    // Restart the sweep at idx 10; r3 must end up cleared.
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hA5A5A5A5; tick(); we0 = 1'b0;
    ra0 = {5'd0, 5'd3}; #1;
    chk("t5.r3_written", rd0[0 +: W], 32'hA5A5A5A5);
    rst0 = 1'b1; tick(); rst0 = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); check_all("t5.part"); end
    rst0 = 1'b1; tick(); rst0 = 1'b0;
    n = 0;
    while (busy0 && n < 40) begin
      we0 = 1'($urandom); wa0 = 5'd3; wd0 = $urandom; ra0 = {5'd3, 5'd3};
      #1; check_all("t5.busy"); tick(); n++;
    end
    chk("t5.len", W'(n), W'(32));
    we0 = 1'b0; ra0 = {5'd3, 5'd3}; #1;
    chk("t5.r3", rd0[0 +: W], '0);
    check_all("t5.end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
